// File: rtl/mux2to1_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
// State encodings are fixed so that waveforms and debug probes read the same everywhere.
package mux2to1_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arbState_e;

  // The grant state that belongs to a requester index.
  function automatic arbState_e grantStateOf(input logic idx);
    return idx ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/mux2to1_with_logic_gates.sv
// One-bit 2:1 multiplexer built from explicit AND/OR/NOT terms.
// sel=0 passes x0, sel=1 passes x1.
module mux2to1_with_logic_gates (
  input  logic x0,
  input  logic x1,
  input  logic sel,
  output logic y
);

  logic selN;
  logic term0;
  logic term1;

  assign selN  = ~sel;
  assign term0 = x0 & selN;
  assign term1 = x1 & sel;
  assign y     = term0 | term1;

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 mux datapath, with a
// bounded burst length per grant whenever the other requester is waiting.
module mux2to1_rr_arbiter
  import mux2to1_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  arbState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;

  // Owner-relative view so both grant states share one set of transition rules.
  logic ownerIdx;
  logic reqOwn;
  logic reqOther;

  assign ownerIdx = (state_q == ST_GNT1);
  assign reqOwn   = ownerIdx ? req1 : req0;
  assign reqOther = ownerIdx ? req0 : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = grantStateOf(~last_q);
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!reqOwn) begin
          // An abandoned request releases the grant without needing a served beat.
          cnt_d   = '0;
          last_d  = ownerIdx;
          state_d = reqOther ? grantStateOf(~ownerIdx) : ST_IDLE;
        end else if (y_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
            if (reqOther) begin
              last_d  = ownerIdx;
              state_d = grantStateOf(~ownerIdx);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Select follows the upcoming owner and holds its last value through IDLE.
    unique case (state_d)
      ST_GNT0: sel_d = 1'b0;
      ST_GNT1: sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  always_comb begin
    gnt0    = (state_q == ST_GNT0);
    gnt1    = (state_q == ST_GNT1);
    sel     = sel_q;
    y_valid = (gnt0 & req0) | (gnt1 & req1);
  end

  for (genvar b = 0; b < WIDTH; b++) begin : gMux
    mux2to1_with_logic_gates uMux (
      .x0  (x0[b]),
      .x1  (x1[b]),
      .sel (sel_q),
      .y   (y[b])
    );
  end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Self-checking bench for mux2to1_rr_arbiter: directed vector table, corner
// sequences and randomized traffic compared against an ownership/burst model.
module tb_mux2to1_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] x0, x1;
  logic             gnt0, gnt1, sel;
  logic [WIDTH-1:0] y;
  logic             yValid, yReady;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Reference model: who owns the mux (-1 none), beats served in this burst,
  // who released last, and where the select currently points.
  int   mOwner;
  int   mBeats;
  int   mLast;
  logic mSel;

  typedef struct {
    logic             rst, req0, req1;
    logic [WIDTH-1:0] x0, x1;
    logic             rdy;
    logic             eGnt0, eGnt1, eSel, eValid;
    logic [WIDTH-1:0] eY;
  } vec_t;

  vec_t tbl[19];

  mux2to1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .x0      (x0),
    .gnt0    (gnt0),
    .req1    (req1),
    .x1      (x1),
    .gnt1    (gnt1),
    .sel     (sel),
    .y       (y),
    .y_valid (yValid),
    .y_ready (yReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic r, q0, q1, input logic [7:0] d0, d1,
                                 input logic rdy, g0, g1, s, v, input logic [7:0] ey);
    vec_t t;
    t.rst = r; t.req0 = q0; t.req1 = q1; t.x0 = d0; t.x1 = d1; t.rdy = rdy;
    t.eGnt0 = g0; t.eGnt1 = g1; t.eSel = s; t.eValid = v; t.eY = ey;
    return t;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkByte(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic g0, g1, s, v, input logic [WIDTH-1:0] ey);
    checkBit({name, " gnt0"}, gnt0, g0);
    checkBit({name, " gnt1"}, gnt1, g1);
    checkBit({name, " sel"}, sel, s);
    checkBit({name, " y_valid"}, yValid, v);
    checkByte({name, " y"}, y, ey);
  endtask

  task automatic applyStimulus(input logic r, q0, q1, input logic [WIDTH-1:0] d0, d1, input logic rdy);
    rst = r; req0 = q0; req1 = q1; x0 = d0; x1 = d1; yReady = rdy;
  endtask

  task automatic modelReset();
    mOwner = -1; mBeats = 0; mLast = 1; mSel = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit reqOwn, reqOther;
    if (rst) begin
      modelReset();
    end else if (mOwner < 0) begin
      mBeats = 0;
      if (req0 && req1) mOwner = 1 - mLast;
      else if (req0)    mOwner = 0;
      else if (req1)    mOwner = 1;
    end else begin
      reqOwn   = (mOwner == 0) ? req0 : req1;
      reqOther = (mOwner == 0) ? req1 : req0;
      if (!reqOwn) begin
        mLast  = mOwner;
        mOwner = reqOther ? 1 - mOwner : -1;
        mBeats = 0;
      end else if (yReady) begin
        mBeats++;
        if (mBeats == MAX_BURST) begin
          mBeats = 0;
          if (reqOther) begin
            mLast  = mOwner;
            mOwner = 1 - mOwner;
          end
        end
      end
    end
    if (mOwner >= 0) mSel = (mOwner == 1);
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // then let the rising edge happen and advance the model.
  task automatic runCycle(input string name, input logic r, q0, q1,
                          input logic [WIDTH-1:0] d0, d1, input logic rdy);
    logic expValid;
    @(negedge clk);
    applyStimulus(r, q0, q1, d0, d1, rdy);
    #1;
    expValid = ((mOwner == 0) && q0) || ((mOwner == 1) && q1);
    checkOutput(name, mOwner == 0, mOwner == 1, mSel, expValid, mSel ? d1 : d0);
    @(posedge clk);
    modelStep();
  endtask

  task automatic resetDut();
    repeat (2) runCycle("reset", 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1);
  endtask

  initial begin
    logic       p0, p1, r, rdy, served0, served1;
    logic [7:0] d0, d1;

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1);
    repeat (2) @(posedge clk);
    modelReset();

    // Directed table: reset, long single-requester burst, backpressure, tie after IDLE.
    tbl[0]  = mkVec(1, 0, 0, 8'h3C, 8'h00, 1,  0, 0, 0, 0, 8'h3C);
    tbl[1]  = mkVec(0, 1, 0, 8'hA5, 8'h5A, 1,  0, 0, 0, 0, 8'hA5);
    for (int i = 2; i < 12; i++)
      tbl[i] = mkVec(0, 1, 0, 8'hA5, 8'h5A, 1,  1, 0, 0, 1, 8'hA5);
    tbl[12] = mkVec(0, 0, 0, 8'hA5, 8'h5A, 1,  1, 0, 0, 0, 8'hA5);
    tbl[13] = mkVec(0, 0, 1, 8'hA5, 8'hC3, 1,  0, 0, 0, 0, 8'hA5);
    tbl[14] = mkVec(0, 0, 1, 8'hA5, 8'hC3, 0,  0, 1, 1, 1, 8'hC3);
    tbl[15] = mkVec(0, 0, 1, 8'hA5, 8'hC3, 1,  0, 1, 1, 1, 8'hC3);
    tbl[16] = mkVec(0, 0, 0, 8'hA5, 8'hC3, 1,  0, 1, 1, 0, 8'hC3);
    tbl[17] = mkVec(0, 1, 1, 8'hA5, 8'hC3, 1,  0, 0, 1, 0, 8'hC3);
    tbl[18] = mkVec(0, 1, 1, 8'hA5, 8'hC3, 1,  1, 0, 0, 1, 8'hA5);

    foreach (tbl[i]) begin
      @(negedge clk);
      applyStimulus(tbl[i].rst, tbl[i].req0, tbl[i].req1, tbl[i].x0, tbl[i].x1, tbl[i].rdy);
      #1;
      checkOutput($sformatf("table[%0d]", i), tbl[i].eGnt0, tbl[i].eGnt1,
                  tbl[i].eSel, tbl[i].eValid, tbl[i].eY);
      @(posedge clk);
      modelStep();
    end

    // Both requesting from reset: bursts of four alternate with no gap.
    resetDut();
    for (int k = 0; k < 24; k++) begin
      runCycle("both", 1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1);
      #1;
      checkBit("both sel pattern", sel, ((k / MAX_BURST) % 2) == 1);
      checkBit("both full throughput", yValid, 1'b1);
    end

    // Backpressure in the middle of a GNT1 burst.
    resetDut();
    runCycle("bp grant", 1'b0, 1'b0, 1'b1, 8'h10, 8'h77, 1'b1);
    repeat (2) runCycle("bp beat", 1'b0, 1'b0, 1'b1, 8'h10, 8'h77, 1'b1);
    repeat (5) begin
      runCycle("bp stall", 1'b0, 1'b1, 1'b1, 8'h10, 8'h77, 1'b0);
      #1;
      checkBit("bp gnt1 held", gnt1, 1'b1);
      checkByte("bp y stable", y, 8'h77);
    end
    runCycle("bp resume", 1'b0, 1'b1, 1'b1, 8'h10, 8'h77, 1'b1);
    #1;
    checkBit("bp one beat left", gnt1, 1'b1);
    runCycle("bp resume", 1'b0, 1'b1, 1'b1, 8'h10, 8'h77, 1'b1);
    #1;
    checkBit("bp handed to 0", gnt0, 1'b1);

    // Owner abandons its request mid-burst; the other side gets a fresh burst.
    resetDut();
    runCycle("drop grant", 1'b0, 1'b1, 1'b0, 8'h44, 8'h88, 1'b1);
    repeat (2) runCycle("drop beat", 1'b0, 1'b1, 1'b1, 8'h44, 8'h88, 1'b1);
    runCycle("drop", 1'b0, 1'b0, 1'b1, 8'h44, 8'h88, 1'b1);
    #1;
    checkBit("drop gnt1", gnt1, 1'b1);
    checkBit("drop sel", sel, 1'b1);
    repeat (3) begin
      runCycle("drop burst", 1'b0, 1'b1, 1'b1, 8'h44, 8'h88, 1'b1);
      #1;
      checkBit("drop count restarted", gnt1, 1'b1);
    end
    runCycle("drop burst", 1'b0, 1'b1, 1'b1, 8'h44, 8'h88, 1'b1);
    #1;
    checkBit("drop burst ends", gnt0, 1'b1);

    // Reset in the middle of a GNT1 burst, then a tie.
    resetDut();
    runCycle("midrst grant", 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
    repeat (2) runCycle("midrst beat", 1'b0, 1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
    runCycle("midrst pulse", 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1);
    #1;
    checkBit("midrst gnt1 cleared", gnt1, 1'b0);
    checkBit("midrst sel cleared", sel, 1'b0);
    runCycle("midrst idle", 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 1'b1);
    #1;
    checkBit("midrst gnt0 first", gnt0, 1'b1);

    // Randomized traffic obeying the hold-until-served rule, with rare
    // abandoned requests and rare resets.
    resetDut();
    p0 = 1'b0; p1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (!p0 && $urandom_range(0, 1) == 1) begin p0 = 1'b1; d0 = 8'($urandom_range(0, 255)); end
      if (!p1 && $urandom_range(0, 1) == 1) begin p1 = 1'b1; d1 = 8'($urandom_range(0, 255)); end
      if (p0 && $urandom_range(0, 39) == 0) p0 = 1'b0;
      if (p1 && $urandom_range(0, 39) == 0) p1 = 1'b0;
      served0 = !r && (mOwner == 0) && p0 && rdy;
      served1 = !r && (mOwner == 1) && p1 && rdy;
      runCycle("rand", r, p0, p1, d0, d1, rdy);
      if (served0 || r) p0 = 1'b0;
      if (served1 || r) p1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
